hdp_spi_responder: RTL and testbench
====================================

Name: hdp_spi_responder

Overview:
- SPI slave that models the HDP configuration interface, i.e. the device end of the link that the comms master drives.
- Oversamples SEN/SCK/SDAT in the system clock domain and decodes 16-bit frames.
- Holds the HDP register subset: mode, serial row MSB/LSB, serial command, clock, and the read-only HW_CONFIG.
- Enforces the standby-to-active dwell and exports decoded state to display logic and testbenches.

Parameters:
HW_ID, 'h20, value returned on read of HW_CONFIG (0x78)
STANDBY_CYCLES, 960000, minimum i_clock cycles in standby before active mode is accepted
SYNC_STAGES, 2, synchroniser depth on i_sen/i_sck/i_sdat (minimum 2)

Ports:
i_clock  in  1  system clock, at least 4x SCK frequency
i_reset  in  1  asynchronous, active-high reset
i_sen  in  1  chip select, active low
i_sck  in  1  serial clock; data sampled on rising edge
i_sdat  in  1  serial data from master
o_sout  out  1  serial read data to master
o_mode  out  2  HDP mode: 0 off, 1 standby, 2 active
o_serialRow  out  16  {MSB reg 0x06, LSB reg 0x07}
o_returnRow  out  16  row latched by command 0x30
o_currentRow  out  16  row latched by command 0x40
o_clockMhz  out  8  register 0x09
o_wrStrobe  out  1  one-cycle pulse per committed write
o_wrAddress  out  7  address of last committed write
o_frameError  out  1  one-cycle pulse on aborted frame
o_modeViolation  out  1  one-cycle pulse on rejected mode write

Behaviour:
- Reset values: all outputs 0, all registers 0, FSM in IDLE.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronised signals; all logic runs on i_clock.
- Frame format, 16 bits, MSB first:
  - bit15 = R/W (1 read).
  - bits14:8 = address.
  - bits7:0 = write data (ignored on read).
- FSM states:
  - IDLE: wait for SEN falling edge; clear bit counter, go to ADDR.
  - ADDR: shift 8 bits on SCK rising edges. After the 8th, go to READ (R/W=1) or WRITE (R/W=0).
  - READ:
    - Load shift-out register with read data, combinationally muxed from the address.
    - Present bit7 on o_sout on the next SCK falling edge, then shift one bit per falling edge (bit7 first).
    - After the 16th rising edge, go to DONE.
  - WRITE: shift 8 data bits. On the 16th rising edge, commit in the same cycle and go to DONE. o_wrStrobe and o_wrAddress are valid the following cycle.
  - DONE: ignore further SCK edges; on SEN rising edge go to IDLE.
- SEN rising edge in ADDR/READ/WRITE (fewer than 16 bits): abort, no commit, pulse o_frameError, go to IDLE.
- o_sout is 0 outside READ.
- Read map:
  - 0x78 returns HW_ID.
  - 0x01 returns {6'b0, mode}.
  - 0x06, 0x07, 0x09 return stored values.
  - 0x08 returns 0x00.
  - All other addresses return 0x00.
- Write map:
  - 0x06/0x07/0x09: store data.
  - 0x08: 0x30 makes returnRow <= serialRow; 0x40 makes currentRow <= serialRow; other values are no-ops. Not stored.
  - 0x78 and unmapped addresses: ignored, but o_wrStrobe still pulses.
  - 0x01: mode-transition rules below.
- Mode rules:
  - Write 0: always accepted.
  - Write 1: always accepted; clears the dwell counter.
  - Write 2: accepted only when mode==1 and dwell counter >= STANDBY_CYCLES. Otherwise mode is unchanged and o_modeViolation pulses.
  - Write 3: rejected with o_modeViolation.
- Dwell counter: 20 bits minimum, width derived from STANDBY_CYCLES. Increments while mode==1, saturates at STANDBY_CYCLES, clears when mode!=1.
- A row command and a serialRow write cannot occur together, since one commit happens per frame.
- Reset mid-frame: immediate return to IDLE with all registers cleared. If SEN is low at reset release, wait for SEN high before accepting a frame.

Test Plan:
1. Read frame {1,0x78,xx} at SCK = clk/8 -> o_sout returns 0x20 MSB-first; no o_wrStrobe.
2. Writes 0x06<-0x01, 0x07<-0x2C, 0x08<-0x30, 0x08<-0x40:
   - o_serialRow=0x012C, o_returnRow=0x012C, o_currentRow=0x012C.
   - Four o_wrStrobe pulses.
   - Readback of 0x08 gives 0x00.
3. Write 0x01<-1, then 0x01<-2 after 1000 cycles -> o_modeViolation pulses, o_mode=1. Repeat after >=960000 cycles -> o_mode=2.
4. Drop SEN after 11 bits of write 0x09<-0x32 -> o_frameError pulses, o_clockMhz stays 0. Next full frame writes 0x32 correctly.
5. Assert i_reset during bit 12 of a read with o_mode=2:
   - All outputs go 0 immediately; o_sout goes 0.
   - Holding SEN low through reset release is ignored until SEN goes high.
6. Write 0x01<-3 and 0x01<-2 from mode 0 -> o_modeViolation each, o_mode=0; write to 0x78 leaves readback 0x20.

Source files
------------

// File: rtl/hdp_spi_responder.sv
// HDP configuration SPI slave: oversampled SEN/SCK/SDAT, 16-bit R/W frames, register subset with mode dwell.
// Frame decode runs entirely on i_clock; read data shifts out on SCK falling edges, writes commit on the 16th rise.
module hdp_spi_responder #(
   parameter logic [7:0] HW_ID          = 8'h20,
   parameter int         STANDBY_CYCLES = 960000,
   parameter int         SYNC_STAGES    = 2
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_sen,
   input  logic        i_sck,
   input  logic        i_sdat,
   output logic        o_sout,
   output logic [1:0]  o_mode,
   output logic [15:0] o_serialRow,
   output logic [15:0] o_returnRow,
   output logic [15:0] o_currentRow,
   output logic [7:0]  o_clockMhz,
   output logic        o_wrStrobe,
   output logic [6:0]  o_wrAddress,
   output logic        o_frameError,
   output logic        o_modeViolation
);

   localparam int DW_RAW = $clog2(STANDBY_CYCLES + 1);
   localparam int DW     = (DW_RAW > 20) ? DW_RAW : 20;
   localparam logic [DW-1:0] STANDBY_MAX = DW'(STANDBY_CYCLES);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_READ, S_WRITE, S_DONE} state_t;

   logic [SYNC_STAGES-1:0] r_sen_sync, r_sck_sync, r_sdat_sync;
   logic                   r_sen_d, r_sck_d;
   state_t                 r_state, w_next;
   logic [3:0]             r_bit_cnt;
   logic [6:0]             r_shift;
   logic [6:0]             r_addr;
   logic [7:0]             r_tx;
   logic                   r_sout;
   logic [1:0]             r_mode;
   logic [7:0]             r_row_msb, r_row_lsb, r_clock;
   logic [15:0]            r_return_row, r_current_row;
   logic                   r_wr_strobe, r_frame_err, r_mode_viol;
   logic [6:0]             r_wr_addr;
   logic [DW-1:0]          r_dwell;

   logic       w_sen, w_sck, w_sdat;
   logic       w_sen_fall, w_sen_rise, w_sck_rise, w_sck_fall;
   logic [7:0] w_shift_nxt;
   logic [7:0] w_rd_data;
   logic       w_in_frame, w_shift_en, w_commit, w_abort, w_load_tx, w_sout_en;

   // SEN synchroniser resets low, so a frame can only start after SEN is seen high first.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_sen_sync  <= '0;
         r_sck_sync  <= '0;
         r_sdat_sync <= '0;
         r_sen_d     <= 1'b0;
         r_sck_d     <= 1'b0;
      end else begin
         r_sen_sync  <= {r_sen_sync[SYNC_STAGES-2:0], i_sen};
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
         r_sdat_sync <= {r_sdat_sync[SYNC_STAGES-2:0], i_sdat};
         r_sen_d     <= w_sen;
         r_sck_d     <= w_sck;
      end
   end

   assign w_sen       = r_sen_sync[SYNC_STAGES-1];
   assign w_sck       = r_sck_sync[SYNC_STAGES-1];
   assign w_sdat      = r_sdat_sync[SYNC_STAGES-1];
   assign w_sen_fall  = r_sen_d & ~w_sen;
   assign w_sen_rise  = ~r_sen_d & w_sen;
   assign w_sck_rise  = ~r_sck_d & w_sck;
   assign w_sck_fall  = r_sck_d & ~w_sck;
   assign w_shift_nxt = {r_shift, w_sdat};

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_sen_fall) w_next = S_ADDR;
         S_ADDR: begin
            if (w_sen_rise)                              w_next = S_IDLE;
            else if (w_sck_rise && r_bit_cnt == 4'd7)    w_next = w_shift_nxt[7] ? S_READ : S_WRITE;
         end
         S_READ, S_WRITE: begin
            if (w_sen_rise)                              w_next = S_IDLE;
            else if (w_sck_rise && r_bit_cnt == 4'd15)   w_next = S_DONE;
         end
         S_DONE:  if (w_sen_rise) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_in_frame = (r_state == S_ADDR) || (r_state == S_READ) || (r_state == S_WRITE);
      w_abort    = w_in_frame && w_sen_rise;
      w_shift_en = w_in_frame && w_sck_rise && !w_sen_rise;
      w_load_tx  = (r_state == S_ADDR) && w_shift_en && (r_bit_cnt == 4'd7) && w_shift_nxt[7];
      w_commit   = (r_state == S_WRITE) && w_shift_en && (r_bit_cnt == 4'd15);
      w_sout_en  = (r_state == S_READ);
   end

   always_comb begin
      case (w_shift_nxt[6:0])
         7'h78:   w_rd_data = HW_ID;
         7'h01:   w_rd_data = {6'b0, r_mode};
         7'h06:   w_rd_data = r_row_msb;
         7'h07:   w_rd_data = r_row_lsb;
         7'h09:   w_rd_data = r_clock;
         default: w_rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_addr    <= '0;
         r_tx      <= '0;
         r_sout    <= 1'b0;
      end else begin
         if (r_state == S_IDLE)  r_bit_cnt <= '0;
         else if (w_shift_en)    r_bit_cnt <= r_bit_cnt + 4'd1;
         if (w_shift_en)         r_shift   <= w_shift_nxt[6:0];
         if ((r_state == S_ADDR) && w_shift_en && (r_bit_cnt == 4'd7))
            r_addr <= w_shift_nxt[6:0];
         if (w_load_tx) begin
            r_tx   <= w_rd_data;
            r_sout <= 1'b0;
         end else if ((r_state == S_READ) && w_sck_fall) begin
            r_sout <= r_tx[7];
            r_tx   <= {r_tx[6:0], 1'b0};
         end
      end
   end

   // Register file, row commands and mode-transition policy; one commit per frame at most.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_mode        <= '0;
         r_row_msb     <= '0;
         r_row_lsb     <= '0;
         r_clock       <= '0;
         r_return_row  <= '0;
         r_current_row <= '0;
         r_wr_strobe   <= 1'b0;
         r_wr_addr     <= '0;
         r_frame_err   <= 1'b0;
         r_mode_viol   <= 1'b0;
         r_dwell       <= '0;
      end else begin
         r_wr_strobe <= w_commit;
         r_frame_err <= w_abort;
         r_mode_viol <= 1'b0;

         if (r_mode != 2'd1)             r_dwell <= '0;
         else if (r_dwell < STANDBY_MAX) r_dwell <= r_dwell + DW'(1);

         if (w_commit) begin
            r_wr_addr <= r_addr;
            case (r_addr)
               7'h06: r_row_msb <= w_shift_nxt;
               7'h07: r_row_lsb <= w_shift_nxt;
               7'h09: r_clock   <= w_shift_nxt;
               7'h08: begin
                  if (w_shift_nxt == 8'h30)      r_return_row  <= {r_row_msb, r_row_lsb};
                  else if (w_shift_nxt == 8'h40) r_current_row <= {r_row_msb, r_row_lsb};
               end
               7'h01: begin
                  if (w_shift_nxt == 8'd0) begin
                     r_mode <= 2'd0;
                  end else if (w_shift_nxt == 8'd1) begin
                     r_mode  <= 2'd1;
                     r_dwell <= '0;
                  end else if (w_shift_nxt == 8'd2 && r_mode == 2'd1 && r_dwell >= STANDBY_MAX) begin
                     r_mode <= 2'd2;
                  end else begin
                     r_mode_viol <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_sout          = r_sout & w_sout_en;
   assign o_mode          = r_mode;
   assign o_serialRow     = {r_row_msb, r_row_lsb};
   assign o_returnRow     = r_return_row;
   assign o_currentRow    = r_current_row;
   assign o_clockMhz      = r_clock;
   assign o_wrStrobe      = r_wr_strobe;
   assign o_wrAddress     = r_wr_addr;
   assign o_frameError    = r_frame_err;
   assign o_modeViolation = r_mode_viol;

endmodule

// File: tb/tb_hdp_spi_responder.sv
// Directed bench for hdp_spi_responder: SCK = clk/8 frames, register map, mode dwell, abort and reset cases.
module tb_hdp_spi_responder;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_sen   = 1'b1;
   logic        i_sck   = 1'b0;
   logic        i_sdat  = 1'b0;
   logic        o_sout;
   logic [1:0]  o_mode;
   logic [15:0] o_serialRow, o_returnRow, o_currentRow;
   logic [7:0]  o_clockMhz;
   logic        o_wrStrobe;
   logic [6:0]  o_wrAddress;
   logic        o_frameError, o_modeViolation;

   int checks = 0;
   int errors = 0;
   int n_wr = 0, n_fe = 0, n_mv = 0;
   int wr0, fe0, mv0;
   logic [7:0]  rx;
   logic [15:0] tx;

   hdp_spi_responder #(.HW_ID(8'h20), .STANDBY_CYCLES(2000), .SYNC_STAGES(2)) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_sen(i_sen), .i_sck(i_sck), .i_sdat(i_sdat),
      .o_sout(o_sout), .o_mode(o_mode), .o_serialRow(o_serialRow), .o_returnRow(o_returnRow),
      .o_currentRow(o_currentRow), .o_clockMhz(o_clockMhz), .o_wrStrobe(o_wrStrobe),
      .o_wrAddress(o_wrAddress), .o_frameError(o_frameError), .o_modeViolation(o_modeViolation)
   );

   always #5 i_clock = ~i_clock;

   always @(posedge i_clock) begin
      if (o_wrStrobe)      n_wr <= n_wr + 1;
      if (o_frameError)    n_fe <= n_fe + 1;
      if (o_modeViolation) n_mv <= n_mv + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge i_clock);
      #1;
   endtask

   task automatic snap();
      wr0 = n_wr; fe0 = n_fe; mv0 = n_mv;
   endtask

   // One SCK period is 8 clocks; master samples o_sout just before each rising edge.
   task automatic frame(input logic [15:0] t, input int nbits, output logic [7:0] r);
      r = 8'h00;
      i_sen = 1'b0;
      wait_clk(4);
      for (int i = 0; i < nbits; i++) begin
         i_sdat = t[15-i];
         i_sck  = 1'b0;
         wait_clk(4);
         if (i >= 8) r = {r[6:0], o_sout};
         i_sck = 1'b1;
         wait_clk(4);
      end
      i_sck = 1'b0;
      wait_clk(4);
      i_sen = 1'b1;
      wait_clk(6);
   endtask

   initial begin
      wait_clk(3);
      check("rst_mode",  o_mode, 0);
      check("rst_row",   o_serialRow, 0);
      check("rst_sout",  o_sout, 0);
      check("rst_clk",   o_clockMhz, 0);
      i_reset = 1'b0;
      wait_clk(4);

      // 1: HW_CONFIG read
      snap();
      frame(16'hF800, 16, rx);
      check("rd_hwid", rx, 8'h20);
      check("rd_no_strobe", n_wr - wr0, 0);

      // 2: row registers and row commands
      snap();
      frame(16'h0601, 16, rx);
      frame(16'h072C, 16, rx);
      frame(16'h0830, 16, rx);
      frame(16'h0840, 16, rx);
      check("serial_row",  o_serialRow, 16'h012C);
      check("return_row",  o_returnRow, 16'h012C);
      check("current_row", o_currentRow, 16'h012C);
      check("wr_strobes",  n_wr - wr0, 4);
      check("wr_addr",     o_wrAddress, 7'h08);
      frame(16'h8800, 16, rx);
      check("rd_cmd_reg", rx, 8'h00);
      frame(16'h8700, 16, rx);
      check("rd_row_lsb", rx, 8'h2C);

      // 3: standby dwell
      frame(16'h0101, 16, rx);
      check("mode_standby", o_mode, 1);
      wait_clk(1000);
      snap();
      frame(16'h0102, 16, rx);
      check("early_active_viol", n_mv - mv0, 1);
      check("early_active_mode", o_mode, 1);
      wait_clk(2000);
      snap();
      frame(16'h0102, 16, rx);
      check("active_no_viol", n_mv - mv0, 0);
      check("mode_active", o_mode, 2);
      frame(16'h8100, 16, rx);
      check("rd_mode", rx, 8'h02);

      // 4: aborted frame then a complete one
      snap();
      frame(16'h0932, 11, rx);
      check("abort_fe", n_fe - fe0, 1);
      check("abort_no_wr", n_wr - wr0, 0);
      check("abort_clk", o_clockMhz, 0);
      frame(16'h0932, 16, rx);
      check("clk_written", o_clockMhz, 8'h32);

      // 5: reset during bit 12 of a read of 0x07 (0x2C: bit 12 carries d3 = 1)
      tx = 16'h8700;
      i_sen = 1'b0;
      wait_clk(4);
      for (int i = 0; i < 12; i++) begin
         i_sdat = tx[15-i];
         i_sck  = 1'b0;
         wait_clk(4);
         i_sck = 1'b1;
         wait_clk(4);
      end
      i_sck = 1'b0;
      wait_clk(4);
      check("pre_rst_sout", o_sout, 1);
      i_reset = 1'b1;
      #1;
      check("rst_mid_sout", o_sout, 0);
      check("rst_mid_mode", o_mode, 0);
      check("rst_mid_rows", {o_serialRow, o_returnRow, o_currentRow}, 0);
      check("rst_mid_clk",  o_clockMhz, 0);
      wait_clk(3);
      i_reset = 1'b0;
      wait_clk(4);
      snap();
      tx = 16'h0955;
      for (int i = 0; i < 16; i++) begin
         i_sdat = tx[15-i];
         i_sck  = 1'b0;
         wait_clk(4);
         i_sck = 1'b1;
         wait_clk(4);
      end
      i_sck = 1'b0;
      wait_clk(4);
      check("sen_low_ignored_wr", n_wr - wr0, 0);
      check("sen_low_ignored_clk", o_clockMhz, 0);
      i_sen = 1'b1;
      wait_clk(6);
      frame(16'h0907, 16, rx);
      check("post_rst_wr", o_clockMhz, 8'h07);

      // 6: illegal mode writes from off; HW_CONFIG is read-only
      snap();
      frame(16'h0103, 16, rx);
      check("mode3_mode", o_mode, 0);
      frame(16'h0102, 16, rx);
      check("mode2_from_off_mode", o_mode, 0);
      check("mode_viol_count", n_mv - mv0, 2);
      snap();
      frame(16'h7812, 16, rx);
      check("ro_wr_strobe", n_wr - wr0, 1);
      check("ro_wr_addr", o_wrAddress, 7'h78);
      frame(16'hF800, 16, rx);
      check("ro_readback", rx, 8'h20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
